// File: rtl/gate_selftest_pkg.sv
// gate_selftest_pkg: shared types and constants for the gate-bank self-test.
//   state_e     - sequencer states
//   *_B         - bit positions of each gate within res / fail_mask
//   VEC_W/ERR_W - widths of the vector counter and the error counter
package gate_selftest_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_e;

  localparam int NAND_B = 4;
  localparam int INV_B  = 3;
  localparam int AND_B  = 2;
  localparam int OR_B   = 1;
  localparam int XOR_B  = 0;
  localparam int NGATES = 5;

  localparam int VEC_W  = 2;
  localparam int ERR_W  = 3;
endpackage

// File: rtl/gate_selftest_if.sv
// gate_selftest_if: bundles the controller/gate-bank side signals of the self-test.
//   start          controller -> sequencer, start a run
//   res[4:0]       gate bank  -> sequencer, gate outputs (nand,inv,and,or,xor)
//   a, b           sequencer  -> gate bank, stimulus
//   busy, done     sequencer  -> controller, run status
//   pass, fail_mask, first_fail_vec, err_cnt   run results
// slave: the sequencer. master: the controller/gate-bank side.
interface gate_selftest_if;
  import gate_selftest_pkg::*;

  logic              start;
  logic [NGATES-1:0] res;
  logic              a;
  logic              b;
  logic              busy;
  logic              done;
  logic              pass;
  logic [NGATES-1:0] fail_mask;
  logic [VEC_W-1:0]  first_fail_vec;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output start, res,
    input  a, b, busy, done, pass, fail_mask, first_fail_vec, err_cnt
  );

  modport slave (
    input  start, res,
    output a, b, busy, done, pass, fail_mask, first_fail_vec, err_cnt
  );
endinterface

// File: rtl/gate_selftest_ref_model.sv
// gate_ref_model: combinational ideal truth table of the gate bank.
//   a_i, b_i   gate inputs
//   exp_o[4:0] expected {nand, inv(a), and, or, xor}
module gate_ref_model
  import gate_selftest_pkg::*;
(
  input  logic              a_i,
  input  logic              b_i,
  output logic [NGATES-1:0] exp_o
);
  always_comb begin
    exp_o         = '0;
    exp_o[NAND_B] = ~(a_i & b_i);
    exp_o[INV_B]  = ~a_i;
    exp_o[AND_B]  = a_i & b_i;
    exp_o[OR_B]   = a_i | b_i;
    exp_o[XOR_B]  = a_i ^ b_i;
  end
endmodule

// File: rtl/gate_selftest.sv
// gate_selftest: self-test sequencer for the NAND-derived gate bank.
// Walks {a,b} through 00,01,10,11, waits SETTLE_CYCLES per vector, samples res
// in a one-cycle CHECK state and accumulates mismatches against gate_ref_model.
//   clk, rst  clock, asynchronous active-high reset
//   bus       gate_selftest_if.slave (start/res in; stimulus, status, results out)
// Config macro: GATE_SELFTEST_XOR_EN - when defined res[0] (xor) is checked;
// otherwise it is ignored and fail_mask[0] stays 0.
module gate_selftest
  import gate_selftest_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1  // 1..15
) (
  input  logic           clk,
  input  logic           rst,
  gate_selftest_if.slave bus
);
`ifdef GATE_SELFTEST_XOR_EN
  localparam logic [NGATES-1:0] CHK_MASK = 5'b11111;
`else
  localparam logic [NGATES-1:0] CHK_MASK = 5'b11110;
`endif
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_e            state_q;
  logic [VEC_W-1:0]  vec_q;
  logic [3:0]        settle_q;
  logic              a_q, b_q, busy_q, done_q, pass_q;
  logic [NGATES-1:0] fail_mask_q;
  logic [VEC_W-1:0]  ffv_q;
  logic [ERR_W-1:0]  err_q, err_d;

  logic [NGATES-1:0] exp_res, mism;

  // vec_q always equals {a_q,b_q}; the model runs off the counter.
  gate_ref_model u_ref (
    .a_i   (vec_q[1]),
    .b_i   (vec_q[0]),
    .exp_o (exp_res)
  );

  assign mism  = (bus.res ^ exp_res) & CHK_MASK;
  assign err_d = (|mism) ? err_q + 3'd1 : err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      ffv_q       <= '0;
      err_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          fail_mask_q <= '0;
          err_q       <= '0;
          ffv_q       <= '0;
          pass_q      <= 1'b0;
          vec_q       <= '0;
          a_q         <= 1'b0;
          b_q         <= 1'b0;
          settle_q    <= SETTLE_LD;
          busy_q      <= 1'b1;
          state_q     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          settle_q <= settle_q - 4'd1;
          if (settle_q == 4'd1) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          err_q <= err_d;
          if (|mism) begin
            fail_mask_q <= fail_mask_q | mism;
            if (err_q == '0) ffv_q <= vec_q;
          end
          if (vec_q == 2'd3) begin
            // pass uses the post-update count so it is valid with done
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= ST_DONE;
          end else begin
            vec_q      <= vec_q + 2'd1;
            {a_q, b_q} <= vec_q + 2'd1;
            settle_q   <= SETTLE_LD;
            state_q    <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.a              = a_q;
  assign bus.b              = b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_mask      = fail_mask_q & CHK_MASK;
  assign bus.first_fail_vec = ffv_q;
  assign bus.err_cnt        = err_q;
endmodule
